mem_port_master: RTL and testbench
==================================

Name: mem_port_master

Overview:
- Initiator side of the single-port unified instruction/data RAM: 8192 x 32, one-cycle synchronous read, no read data during a write cycle.
- Arbitrates between the CPU instruction-fetch port and the load/store port.
- Converts byte addresses to word addresses and drives the RAM's W_En/Addr/D_In.
- Returns each response two cycles after acceptance. Sits between the core and the RAM.

Parameters:
- ADDR_W, 13, RAM word-address width (8192 words).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction fetch request (read only).
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  combinational; fetch accepted this cycle.
- i_rsp_valid  out  1  fetch response valid (one-cycle pulse).
- i_rsp_data  out  DATA_W  fetch data, qualified by i_rsp_valid.
- i_rsp_err  out  1  fetch address error, qualified by i_rsp_valid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  combinational; data request accepted this cycle.
- d_rsp_valid  out  1  data response / write ack (one-cycle pulse).
- d_rsp_data  out  DATA_W  read data, qualified by d_rsp_valid.
- d_rsp_err  out  1  data address error, qualified by d_rsp_valid.
- mem_we  out  1  to RAM W_En.
- mem_addr  out  ADDR_W  to RAM Addr.
- mem_din  out  DATA_W  to RAM D_In.
- mem_dout  in  DATA_W  from RAM D_Out.

Behaviour:
- Reset (async, rst_n=0): mem_we=0, mem_addr=0, mem_din=0, all rsp_valid=0, rsp_err=0, starve counter=0, pipeline valid bits cleared.
- Reset mid-operation: in-flight accesses are dropped with no response. The first cycle after release is idle.
- Pipeline:
  - C0: request granted.
  - Edge E1: mem_* registers load, plus issue-stage owner/we/err/valid.
  - Edge E2: the RAM sampled mem_* at E2 and D_Out is updated; the response-stage registers load from the issue stage.
  - C2 (after E2): x_rsp_valid=1; x_rsp_data = mem_dout if read and no error, else 0.
  - Latency is exactly 2 cycles for every access. Throughput is one access per cycle with no bubbles.
- Grant logic (combinational; one grant per cycle):
  - Only one requester active: grant it.
  - Both active: grant data, unless the starve counter equals STARVE_MAX, in which case grant instruction.
- Starve counter:
  - Increments when data is granted while i_req=1.
  - Clears on any instruction grant or when i_req=0.
  - Saturates at STARVE_MAX.
- Requester protocol: a requester holds req/addr/wdata stable until it sees its gnt.
- Address check: error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
  - On error, the slot is consumed: mem_we=0, mem_addr keeps its previous value, no RAM write.
  - The response arrives in C2 with err=1 and data=0.
- Word address: mem_addr = addr[ADDR_W+1:2].
- Writes: mem_we=1 for exactly the one issue cycle. d_rsp_valid pulses in C2 as the write ack with d_rsp_data=0.
- Idle cycles: mem_we=0, mem_addr/mem_din hold their previous values.
- Write then read of the same word on consecutive grants: the read returns the newly written data, because the RAM write completes at the earlier edge.
- mem_dout handling: the RAM does not update D_Out on a write cycle, so read data is taken only for read slots. Reads are never forwarded from a write.

Decomposition:
- Shared package mem_port_pkg holds:
  - MEM_ADDR_W=13, MEM_DATA_W=32.
  - Owner encoding OWN_I=0, OWN_D=1.
  - The address-error function.
- One sub-module, mem_port_arb: priority/starvation grant logic and its counter.
- The datapath and the pipeline registers stay in the top.

Test Plan:
- Read latency: preload word 5 = 0xDEADBEEF; i_req with i_addr=0x14 in C0. Expect i_gnt=1 in C0, mem_addr=5 after E1, then i_rsp_valid=1 and i_rsp_data=0xDEADBEEF in C2 only.
- Write then read back-to-back: d_we=1, d_addr=0x40, d_wdata=0x12345678; next cycle read 0x40. Expect mem_we=1 for one cycle, a write ack in C2, and a read response of 0x12345678 in C3.
- Contention: i_req and d_req both held for 8 cycles with STARVE_MAX=4. Expect grants D,D,D,D,I,D,D,D and no lost responses.
- Errors:
  - d_addr=0x42 (misaligned): d_rsp_err=1, data 0, mem_we stays 0.
  - i_addr=0x8000 (out of range): i_rsp_err=1.
- Async reset: assert rst_n=0 between E1 and E2 of a pending read. Expect all outputs at reset values immediately and no i_rsp_valid after release.
- Streaming: 16 consecutive fetches, 0x0..0x3C. Expect 16 contiguous i_rsp_valid cycles, in order, starting 2 cycles after the first grant.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared definitions for the unified I/D RAM initiator.
//   MEM_ADDR_W / MEM_DATA_W : RAM geometry (8192 x 32)
//   own_e                   : which requester owns a pipeline slot
//   slot_t                  : per-stage bookkeeping carried alongside the valid bit
//   addr_err()              : byte-address legality check
package mem_port_pkg;
   localparam int MEM_ADDR_W = 13;
   localparam int MEM_DATA_W = 32;

   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_e;

   typedef struct packed {
      own_e own;
      logic we;
      logic err;
   } slot_t;

   // Illegal when not word aligned or when any bit above the RAM word range is set.
   function automatic logic addr_err(input logic [31:0] a, input int aw);
      return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
   endfunction
endpackage

// File: rtl/mem_port_if.sv
// Bus bundle between the core ports, the initiator and the RAM.
//   i_*   : instruction fetch request / grant / response
//   d_*   : load/store request / grant / response
//   mem_* : RAM W_En, Addr, D_In, D_Out
// master = mem_port_master view, slave = core + RAM view.
interface mem_port_if
   import mem_port_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt;
   logic              i_rsp_valid;
   logic [DATA_W-1:0] i_rsp_data;
   logic              i_rsp_err;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_data;
   logic              d_rsp_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
      output i_gnt, i_rsp_valid, i_rsp_data, i_rsp_err,
             d_gnt, d_rsp_valid, d_rsp_data, d_rsp_err,
             mem_we, mem_addr, mem_din
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
      input  i_gnt, i_rsp_valid, i_rsp_data, i_rsp_err,
             d_gnt, d_rsp_valid, d_rsp_data, d_rsp_err,
             mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_port_arb.sv
// Fetch vs load/store arbiter.
//   clk, rst_n     : clock, async active-low reset
//   i_req, d_req   : requests
//   i_gnt, d_gnt   : combinational one-hot (or zero) grants
// Data wins contention until STARVE_MAX consecutive data grants have been
// given to a waiting fetch; the next contended cycle then goes to the fetch.
module mem_port_arb #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;

   assign i_gnt = i_req & (~d_req | (starve_cnt == CMAX));
   assign d_gnt = d_req & ~i_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!i_req || i_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && starve_cnt != CMAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mem_port_master.sv
// Initiator for the single-port unified I/D RAM (one-cycle synchronous read).
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_port_if.master -- fetch port, load/store port, RAM pins
// Two-stage pipeline: grant in C0, mem_* registered at E1 (issue stage),
// response stage loads at E2 while the RAM presents D_Out, response in C2.
// One access per cycle, fixed 2-cycle latency.
module mem_port_master
   import mem_port_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input logic       clk,
   input logic       rst_n,
   mem_port_if.master bus
);
   localparam int STAGES = 1;   // [0] issue, [1] response

   logic i_gnt, d_gnt, gnt_any;
   logic [31:0] req_addr;
   logic req_we, req_err;

   logic [STAGES:0] vld_pipe;
   slot_t [STAGES:0] slot_q;

   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;

   mem_port_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (bus.i_req),
      .d_req (bus.d_req),
      .i_gnt (i_gnt),
      .d_gnt (d_gnt)
   );

   assign gnt_any  = i_gnt | d_gnt;
   assign req_addr = d_gnt ? bus.d_addr : bus.i_addr;
   assign req_we   = d_gnt & bus.d_we;
   assign req_err  = addr_err(req_addr, ADDR_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe   <= '0;
         slot_q     <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         vld_pipe      <= {vld_pipe[STAGES-1:0], gnt_any};
         slot_q[0]     <= '{own: (d_gnt ? OWN_D : OWN_I), we: req_we, err: req_err};
         slot_q[1]     <= slot_q[0];
         // A faulting access still occupies its slot but never touches the RAM.
         mem_we_q      <= gnt_any & req_we & ~req_err;
         if (gnt_any && !req_err)
            mem_addr_q <= req_addr[ADDR_W+1:2];
         if (gnt_any && req_we && !req_err)
            mem_din_q  <= bus.d_wdata;
      end
   end

   // D_Out is only meaningful for read slots: the RAM leaves it stale on writes.
   logic rsp_rd_ok;
   assign rsp_rd_ok = vld_pipe[1] & ~slot_q[1].we & ~slot_q[1].err;

   assign bus.i_gnt       = i_gnt;
   assign bus.d_gnt       = d_gnt;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_din     = mem_din_q;

   assign bus.i_rsp_valid = vld_pipe[1] & (slot_q[1].own == OWN_I);
   assign bus.d_rsp_valid = vld_pipe[1] & (slot_q[1].own == OWN_D);
   assign bus.i_rsp_err   = bus.i_rsp_valid & slot_q[1].err;
   assign bus.d_rsp_err   = bus.d_rsp_valid & slot_q[1].err;
   assign bus.i_rsp_data  = (rsp_rd_ok && slot_q[1].own == OWN_I) ? bus.mem_dout : '0;
   assign bus.d_rsp_data  = (rsp_rd_ok && slot_q[1].own == OWN_D) ? bus.mem_dout : '0;
endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: behavioural 8192x32 RAM, table of single
// accesses, hand-written multi-cycle sequences, and a randomized run checked
// against a transaction-level model (grant rule + shadow memory + queue).
module tb_mem_port_master;
   import mem_port_pkg::*;

   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_if bus();

   mem_port_master #(.STARVE_MAX(SMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // RAM: one-cycle read, D_Out untouched on write cycles.
   logic [31:0] ram [8192];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout      <= ram[bus.mem_addr];
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.i_req = 0; bus.i_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
   endtask

   function automatic logic bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'h8000);
   endfunction

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;
   vec_t tbl[9];

   logic [12:0] last_addr = '0;

   // One isolated access: grant in C0, issue checks in C1, response in C2.
   task automatic apply(input vec_t v);
      logic [31:0] w;
      @(negedge clk);
      idle();
      if (v.is_d) begin
         bus.d_req = 1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.i_req = 1; bus.i_addr = v.addr;
      end
      #1;
      chk("tbl i_gnt", bus.i_gnt, !v.is_d);
      chk("tbl d_gnt", bus.d_gnt, v.is_d);
      @(negedge clk);
      idle();
      #1;
      chk("tbl mem_we", bus.mem_we, v.we && !v.exp_err);
      if (!v.exp_err) begin
         w = v.addr >> 2;
         last_addr = w[12:0];
      end
      chk("tbl mem_addr", bus.mem_addr, last_addr);
      if (v.we && !v.exp_err) chk("tbl mem_din", bus.mem_din, v.wdata);
      chk("tbl early rsp", bus.i_rsp_valid | bus.d_rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("tbl mem_we C2", bus.mem_we, 0);
      if (v.is_d) begin
         chk("tbl d_rsp_valid", bus.d_rsp_valid, 1);
         chk("tbl d_rsp_err", bus.d_rsp_err, v.exp_err);
         chk("tbl d_rsp_data", bus.d_rsp_data, v.exp_data);
         chk("tbl i_rsp_valid", bus.i_rsp_valid, 0);
      end else begin
         chk("tbl i_rsp_valid", bus.i_rsp_valid, 1);
         chk("tbl i_rsp_err", bus.i_rsp_err, v.exp_err);
         chk("tbl i_rsp_data", bus.i_rsp_data, v.exp_data);
         chk("tbl d_rsp_valid", bus.d_rsp_valid, 0);
      end
      @(negedge clk);
      #1;
      chk("tbl rsp one pulse", bus.i_rsp_valid | bus.d_rsp_valid, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0)      return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) return 32'h8000 + (32'($urandom_range(0, 1000)) << 2);
      else if (r == 2) return 32'h8000_0000 | (32'($urandom_range(0, 31)) << 2);
      else             return 32'($urandom_range(0, 31)) << 2;
   endfunction

   typedef struct {
      logic        is_d;
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   initial begin
      logic [31:0] shadow [32];
      exp_t q[$];
      exp_t ex;
      logic ip, dp, dwe, mi, md, e;
      logic [31:0] ia, da, dwd;
      int starve, ni, nd, n_iss, n_rsp, g0;
      logic [7:0] seq;

      idle();
      ram[5]    = 32'hDEADBEEF;
      ram[8191] = 32'hCAFEF00D;

      // ---- reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst mem_we", bus.mem_we, 0);
      chk("rst mem_addr", bus.mem_addr, 0);
      chk("rst mem_din", bus.mem_din, 0);
      chk("rst i_rsp_valid", bus.i_rsp_valid, 0);
      chk("rst d_rsp_valid", bus.d_rsp_valid, 0);
      chk("rst i_rsp_err", bus.i_rsp_err, 0);
      chk("rst d_rsp_err", bus.d_rsp_err, 0);
      @(negedge clk);
      rst_n = 1;

      // ---- table of isolated accesses
      tbl[0] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,          1'b0, 32'hDEADBEEF};
      tbl[1] = '{1'b0, 1'b0, 32'h0000_7FFC, 32'h0,          1'b0, 32'hCAFEF00D};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_0080, 32'hA5A5A5A5,   1'b0, 32'h0};
      tbl[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,          1'b0, 32'hA5A5A5A5};
      tbl[4] = '{1'b1, 1'b1, 32'h0000_0042, 32'h11111111,   1'b1, 32'h0};
      tbl[5] = '{1'b0, 1'b0, 32'h0000_8000, 32'h0,          1'b1, 32'h0};
      tbl[6] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,          1'b1, 32'h0};
      tbl[7] = '{1'b0, 1'b0, 32'h0000_0002, 32'h0,          1'b1, 32'h0};
      tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0};
      for (int k = 0; k < 9; k++) apply(tbl[k]);

      // ---- write then read of the same word on consecutive grants
      @(negedge clk);
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
      #1;
      chk("wr d_gnt", bus.d_gnt, 1);
      @(negedge clk);
      bus.d_we = 0; bus.d_wdata = 0;
      #1;
      chk("rd d_gnt", bus.d_gnt, 1);
      chk("wr mem_we", bus.mem_we, 1);
      chk("wr mem_addr", bus.mem_addr, 16);
      chk("wr mem_din", bus.mem_din, 32'h12345678);
      @(negedge clk);
      idle();
      #1;
      chk("wr mem_we once", bus.mem_we, 0);
      chk("wr ack valid", bus.d_rsp_valid, 1);
      chk("wr ack data", bus.d_rsp_data, 0);
      chk("wr ack err", bus.d_rsp_err, 0);
      @(negedge clk);
      #1;
      chk("rb valid", bus.d_rsp_valid, 1);
      chk("rb data", bus.d_rsp_data, 32'h12345678);
      @(negedge clk);

      // ---- contention: both held for 8 cycles
      ni = 0; nd = 0; seq = '0; n_rsp = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         idle();
         if (c < 8) begin
            bus.i_req = 1; bus.i_addr = 32'(ni) << 2;
            bus.d_req = 1; bus.d_addr = 32'(nd + 32) << 2;
         end
         #1;
         if (c < 8) begin
            chk("cont one-hot", bus.i_gnt ^ bus.d_gnt, 1);
            seq[c] = bus.i_gnt;
            if (bus.i_gnt) ni++;
            if (bus.d_gnt) nd++;
         end
         if (bus.i_rsp_valid || bus.d_rsp_valid) n_rsp++;
      end
      chk("cont grant seq", seq, 8'b0001_0000);
      chk("cont responses", n_rsp, 8);

      // ---- streaming 16 fetches
      for (int k = 0; k < 16; k++) ram[k] = 32'h1000_0000 + k;
      n_iss = 0; n_rsp = 0; g0 = -1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         idle();
         if (n_iss < 16) begin bus.i_req = 1; bus.i_addr = 32'(n_iss) << 2; end
         #1;
         if (bus.i_gnt) begin
            if (g0 < 0) g0 = c;
            n_iss++;
         end
         if (bus.i_rsp_valid) begin
            chk("strm cycle", c, g0 + 2 + n_rsp);
            chk("strm data", bus.i_rsp_data, 32'h1000_0000 + n_rsp);
            n_rsp++;
         end
      end
      chk("strm first gnt", g0, 0);
      chk("strm count", n_rsp, 16);

      // ---- randomized traffic vs transaction model
      for (int k = 0; k < 32; k++) begin
         shadow[k] = $urandom;
         ram[k]    = shadow[k];
      end
      ip = 0; dp = 0; ia = 0; da = 0; dwe = 0; dwd = 0; starve = 0;
      for (int c = 0; c < 403; c++) begin
         @(negedge clk);
         if (c < 400) begin
            if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = rand_addr(); end
            if (!dp && $urandom_range(0, 2) != 0) begin
               dp = 1; dwe = 1'($urandom_range(0, 1)); da = rand_addr(); dwd = $urandom;
            end
         end
         bus.i_req = ip; bus.i_addr = ia;
         bus.d_req = dp; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
         #1;
         mi = ip && (!dp || starve == SMAX);
         md = dp && !mi;
         chk("rnd i_gnt", bus.i_gnt, mi);
         chk("rnd d_gnt", bus.d_gnt, md);
         if (!ip || mi) starve = 0;
         else if (md && starve < SMAX) starve++;
         if (mi) begin
            e = bad(ia);
            q.push_back('{1'b0, e, e ? 32'h0 : shadow[ia[6:2]], c + 2});
            ip = 0;
         end
         if (md) begin
            e = bad(da);
            q.push_back('{1'b1, e, (e || dwe) ? 32'h0 : shadow[da[6:2]], c + 2});
            if (dwe && !e) shadow[da[6:2]] = dwd;
            dp = 0;
         end
         if (q.size() > 0 && q[0].due == c) begin
            ex = q.pop_front();
            chk("rnd i_rsp_valid", bus.i_rsp_valid, !ex.is_d);
            chk("rnd d_rsp_valid", bus.d_rsp_valid, ex.is_d);
            chk("rnd rsp_err", ex.is_d ? bus.d_rsp_err : bus.i_rsp_err, ex.err);
            chk("rnd rsp_data", ex.is_d ? bus.d_rsp_data : bus.i_rsp_data, ex.data);
         end else begin
            chk("rnd no rsp", bus.i_rsp_valid | bus.d_rsp_valid, 0);
         end
      end
      chk("rnd drained", q.size(), 0);
      idle();

      // ---- async reset between E1 and E2 of a pending read
      @(negedge clk);
      bus.i_req = 1; bus.i_addr = 32'h14;
      #1;
      chk("ar i_gnt", bus.i_gnt, 1);
      @(negedge clk);
      idle();
      #1;
      chk("ar mem_addr pre", bus.mem_addr, 5);
      #1;
      rst_n = 0;
      #1;
      chk("ar mem_we", bus.mem_we, 0);
      chk("ar mem_addr", bus.mem_addr, 0);
      chk("ar mem_din", bus.mem_din, 0);
      chk("ar i_rsp_valid", bus.i_rsp_valid, 0);
      chk("ar i_rsp_err", bus.i_rsp_err, 0);
      @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("ar no rsp", bus.i_rsp_valid | bus.d_rsp_valid, 0);
      end
      last_addr = '0;
      apply(tbl[1]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
